// File: rtl/mxint8_pkg.sv
// Shared MXINT8 constants, element/block types and the deserializer FSM state encoding.
package mxint8_pkg;

    localparam int BLOCK_SIZE           = 32;
    localparam int MXINT8_ELEMENT_WIDTH = 8;
    localparam int MXINT8_SCALE_WIDTH   = 8;

    typedef logic [MXINT8_ELEMENT_WIDTH-1:0] mxint8_elem_t;
    typedef logic [MXINT8_SCALE_WIDTH-1:0]   mxint8_scale_t;
    typedef mxint8_elem_t [0:BLOCK_SIZE-1]   mxint8_block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } deser_state_t;

endpackage

// File: rtl/mxint8_elem_clamp.sv
// Per-lane element clamp: maps the most negative code to its neighbour when
// MXINT8_DESER_CLAMP_EN is defined, otherwise a plain pass-through.
module mxint8_elem_clamp #(
    parameter int W = 8
) (
    input  logic [W-1:0] elem_i,
    output logic [W-1:0] elem_o
);

`ifdef MXINT8_DESER_CLAMP_EN
    localparam logic [W-1:0] MOST_NEG     = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_NEG_P1  = {1'b1, {(W-2){1'b0}}, 1'b1};

    // Keeps the block symmetric so a downstream negate cannot overflow.
    assign elem_o = (elem_i == MOST_NEG) ? MOST_NEG_P1 : elem_i;
`else
    assign elem_o = elem_i;
`endif

endmodule

// File: rtl/mxint8_block_deserializer.sv
// Assembles a beat-serial MXINT8 stream into one parallel block with framing checks.
// Optional 0x80 -> 0x81 clamping on the write path via MXINT8_DESER_CLAMP_EN.
module mxint8_block_deserializer #(
    parameter int BLOCK_SIZE  = mxint8_pkg::BLOCK_SIZE,
    parameter int ELEM_WIDTH  = mxint8_pkg::MXINT8_ELEMENT_WIDTH,
    parameter int SCALE_WIDTH = mxint8_pkg::MXINT8_SCALE_WIDTH,
    parameter int LANES       = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic                                   i_first,
    input  logic [SCALE_WIDTH-1:0]                 i_scale,
    input  logic [0:LANES-1][ELEM_WIDTH-1:0]       i_elements,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [SCALE_WIDTH-1:0]                 o_scale,
    output logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0]  o_mxint8_elements,
    output logic                                   o_err
);
    import mxint8_pkg::*;

    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    deser_state_t            state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [SCALE_WIDTH-1:0]  scale_q;
    logic                    err_q;
    logic [ELEM_WIDTH-1:0]   elem_q [BLOCK_SIZE];
    logic [ELEM_WIDTH-1:0]   lane_w [LANES];

    logic                    accept;
    logic                    wr_en;
    logic [CNT_W-1:0]        wr_beat;

    assign o_ready = (state_q != ST_FULL);
    assign o_valid = (state_q == ST_FULL);
    assign o_scale = scale_q;
    assign o_err   = err_q;
    assign accept  = i_valid && o_ready;

    // A first-flagged beat always lands at beat 0, also when it restarts a partial block.
    assign wr_en   = accept && (i_first || (state_q == ST_FILL));
    assign wr_beat = (state_q == ST_FILL && !i_first) ? cnt_q : '0;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            mxint8_elem_clamp #(.W(ELEM_WIDTH)) u_clamp (
                .elem_i (i_elements[gi]),
                .elem_o (lane_w[gi])
            );
        end

        for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_elem
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    elem_q[gi] <= '0;
                end else if (wr_en && (wr_beat == CNT_W'(gi / LANES))) begin
                    elem_q[gi] <= lane_w[gi % LANES];
                end
            end
            assign o_mxint8_elements[gi] = elem_q[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            scale_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (i_first) begin
                            scale_q <= i_scale;
                            if (BEATS == 1) begin
                                state_q <= ST_FULL;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= ST_FILL;
                                cnt_q   <= CNT_W'(1);
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        if (i_first) begin
                            err_q   <= 1'b1;
                            scale_q <= i_scale;
                            cnt_q   <= CNT_W'(1);
                        end else if (cnt_q == CNT_W'(BEATS - 1)) begin
                            state_q <= ST_FULL;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
